// File: rtl/unit_sched_pkg.sv
// Shared types and defaults for the round-robin unit scheduler.
// Holds the scheduler state encoding and default sizing.
package unit_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/unit_sched_rr_pick.sv
// Round-robin winner search: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         any_o,
  output logic [W-1:0] index_o
);

  always_comb begin
    logic [W-1:0] j;
    any_o   = 1'b0;
    index_o = '0;
    j       = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (req_i[j] && !any_o) begin
        any_o   = 1'b1;
        index_o = j;
      end
      j = (j == W'(N - 1)) ? '0 : j + W'(1);
    end
  end

endmodule

// File: rtl/unit_sched.sv
// Arbitrates NUM_REQ requesters onto one shared unit, one job at a time,
// with a bounded wait for completion and a sticky timeout flag.
module unit_sched
  import unit_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IW      = $clog2(NUM_REQ),
  parameter int CW      = $clog2(TIMEOUT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] done,
  input  logic               unit_ready,
  output logic               unit_valid,
  input  logic               unit_done,
  output logic [IW-1:0]      owner,
  output logic               busy,
  output logic               timeout_err
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] owner_nxt;

  rr_pick #(
    .N (NUM_REQ),
    .W (IW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .any_o   (pick_any),
    .index_o (pick_idx)
  );

  assign owner_nxt = (owner_q == IW'(NUM_REQ - 1)) ?
                     '0 : owner_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    req_ready  = '0;
    done       = '0;
    unit_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid = req_valid[owner_q];
        if (!req_valid[owner_q]) begin
          state_d = IDLE;
        end else if (unit_ready) begin
          req_ready[owner_q] = 1'b1;
          state_d            = WAIT;
          cnt_d              = '0;
        end
      end
      WAIT: begin
        if (unit_done) begin
          done[owner_q] = 1'b1;
          state_d       = IDLE;
          ptr_d         = owner_nxt;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort: no done pulse, but still rotate priority.
          state_d = IDLE;
          terr_d  = 1'b1;
          ptr_d   = owner_nxt;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_unit_sched.sv
// Self-checking bench for unit_sched: directed scenarios plus random
// traffic against a cycle-level reference model of the scheduling rules.
module tb_unit_sched;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int W  = $clog2(N);
  localparam int BW = 2 * N + W + 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N-1:0] done;
  logic         unit_ready;
  logic         unit_valid;
  logic         unit_done;
  logic [W-1:0] owner;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unit_sched #(
    .NUM_REQ (N),
    .TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .done        (done),
    .unit_ready  (unit_ready),
    .unit_valid  (unit_valid),
    .unit_done   (unit_done),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Shared unit: ready when idle, done two cycles after accept.
  int u_st = 0;
  bit u_hang = 1'b0;
  bit u_inj = 1'b0;
  bit u_clr = 1'b0;

  assign unit_ready = (u_st == 0);
  assign unit_done  = (u_st == 2) || u_inj;

  always @(posedge clk) begin
    if (u_clr) u_st <= 0;
    else if (u_st == 0) begin
      if (unit_valid) u_st <= 1;
    end else if (u_st == 1) begin
      if (!u_hang) u_st <= 2;
    end else u_st <= 0;
  end

  // Reference model: phase 0 idle, 1 issuing, 2 waiting on unit.
  int m_ph = 0;
  int m_own = 0;
  int m_ptr = 0;
  int m_wt = 0;
  bit m_terr = 1'b0;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph <= 0; m_own <= 0; m_ptr <= 0;
      m_wt <= 0; m_terr <= 1'b0;
    end else if (m_ph == 0) begin
      if (req_valid != '0) begin
        m_own <= pick(req_valid, m_ptr);
        m_ph  <= 1;
      end
    end else if (m_ph == 1) begin
      if (!req_valid[m_own]) m_ph <= 0;
      else if (unit_ready) begin
        m_ph <= 2;
        m_wt <= 0;
      end
    end else begin
      if (unit_done) begin
        m_ph  <= 0;
        m_ptr <= (m_own + 1) % N;
      end else if (m_wt + 1 == T) begin
        m_ph   <= 0;
        m_terr <= 1'b1;
        m_ptr  <= (m_own + 1) % N;
      end else m_wt <= m_wt + 1;
    end
  end

  logic [N-1:0]  e_rr, e_dn;
  logic          e_uv;
  logic [BW-1:0] obs, exp_b;

  always_comb begin
    e_rr = '0;
    e_dn = '0;
    e_uv = 1'b0;
    if (m_ph == 1 && req_valid[m_own]) begin
      e_uv = 1'b1;
      if (unit_ready) e_rr[m_own] = 1'b1;
    end
    if (m_ph == 2 && unit_done) e_dn[m_own] = 1'b1;
  end

  assign obs   = {req_ready, done, unit_valid, busy, owner, timeout_err};
  assign exp_b = {e_rr, e_dn, e_uv, m_ph != 0, W'(m_own), m_terr};

  task automatic do_reset();
    reset = 1'b1; u_clr = 1'b1;
    u_hang = 1'b0; u_inj = 1'b0;
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; u_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; u_clr = 1'b1;
    u_hang = 1'b0; u_inj = 1'b0;
    req_valid = '1;
    repeat (2) begin @(posedge clk); #1; end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_out got=%h want=0", obs);
    end
    reset = 1'b0; u_clr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (obs !== exp_b) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", obs, exp_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [4:0] bmask;
    bmask = 5'b01110;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = (i < 4) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      checks++;
      if (obs !== exp_b) begin
        errors++;
        $display("FAIL single_model c%0d got=%h want=%h", i, obs, exp_b);
      end
      checks++;
      if (busy !== bmask[i]) begin
        errors++;
        $display("FAIL single_busy c%0d got=%b want=%b", i, busy, bmask[i]);
      end
      if (i == 1) begin
        checks++;
        if ({req_ready, unit_valid} !== 5'b00011) begin
          errors++;
          $display("FAIL single_grant got=%b want=00011",
                   {req_ready, unit_valid});
        end
      end
      if (i == 3) begin
        checks++;
        if (done !== 4'b0001) begin
          errors++;
          $display("FAIL single_done got=%b want=0001", done);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      req_valid = '1;
      want = N'(1 << ((i / 4) % N));
      @(negedge clk);
      checks++;
      if (obs !== exp_b) begin
        errors++;
        $display("FAIL fair_model c%0d got=%h want=%h", i, obs, exp_b);
      end
      if (i % 4 == 1) begin
        checks++;
        if (req_ready !== want) begin
          errors++;
          $display("FAIL fair_grant c%0d got=%b want=%b", i, req_ready, want);
        end
      end
      if (i % 4 == 3) begin
        checks++;
        if (done !== want) begin
          errors++;
          $display("FAIL fair_done c%0d got=%b want=%b", i, done, want);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req_valid = (i < 4) ? 4'b0100 : 4'b0011;
      @(negedge clk);
      checks++;
      if (obs !== exp_b) begin
        errors++;
        $display("FAIL wrap_model c%0d got=%h want=%h", i, obs, exp_b);
      end
      if (i == 5) begin
        checks++;
        if ({owner, req_ready} !== {2'd0, 4'b0001}) begin
          errors++;
          $display("FAIL wrap_first got=%0d/%b want=0/0001", owner, req_ready);
        end
      end
      if (i == 9) begin
        checks++;
        if ({owner, req_ready} !== {2'd1, 4'b0010}) begin
          errors++;
          $display("FAIL wrap_second got=%0d/%b want=1/0010", owner, req_ready);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 27; i++) begin
      req_valid = (i < 18) ? 4'b0001 : 4'b0011;
      u_hang = (i < 20);
      @(negedge clk);
      checks++;
      if (obs !== exp_b) begin
        errors++;
        $display("FAIL tmo_model c%0d got=%h want=%h", i, obs, exp_b);
      end
      if (i < 24) begin
        checks++;
        if (done !== '0) begin
          errors++;
          $display("FAIL tmo_nodone c%0d got=%b want=0000", i, done);
        end
      end
      if (i == 17) begin
        checks++;
        if ({timeout_err, busy} !== 2'b01) begin
          errors++;
          $display("FAIL tmo_pre got=%b want=01", {timeout_err, busy});
        end
      end
      if (i == 18) begin
        checks++;
        if ({timeout_err, busy} !== 2'b10) begin
          errors++;
          $display("FAIL tmo_hit got=%b want=10", {timeout_err, busy});
        end
      end
      if (i == 19) begin
        checks++;
        if ({owner, unit_valid, req_ready} !== {2'd1, 1'b1, 4'b0000}) begin
          errors++;
          $display("FAIL tmo_next got=%0d/%b/%b want=1/1/0000",
                   owner, unit_valid, req_ready);
        end
      end
      if (i == 24) begin
        checks++;
        if (done !== 4'b0010) begin
          errors++;
          $display("FAIL tmo_done got=%b want=0010", done);
        end
      end
      if (i == 26) begin
        checks++;
        if (timeout_err !== 1'b1) begin
          errors++;
          $display("FAIL tmo_sticky got=%b want=1", timeout_err);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_withdraw();
    logic [N-1:0] pat [4];
    pat = '{4'b0100, 4'b0000, 4'b0110, 4'b1010};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = pat[(i < 3) ? i : 3];
      @(negedge clk);
      checks++;
      if (obs !== exp_b) begin
        errors++;
        $display("FAIL wdr_model c%0d got=%h want=%h", i, obs, exp_b);
      end
      if (i == 1) begin
        checks++;
        if ({unit_valid, req_ready, busy} !== 6'b000001) begin
          errors++;
          $display("FAIL wdr_drop got=%b want=000001",
                   {unit_valid, req_ready, busy});
        end
      end
      if (i == 3) begin
        checks++;
        if ({owner, req_ready} !== {2'd1, 4'b0010}) begin
          errors++;
          $display("FAIL wdr_ptr got=%0d/%b want=1/0010", owner, req_ready);
        end
      end
      if (i == 7) begin
        checks++;
        if (owner !== 2'd3) begin
          errors++;
          $display("FAIL wdr_rot got=%0d want=3", owner);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 3) ? 4'b0001 : 4'b0000;
      reset = (i == 2);
      @(negedge clk);
      checks++;
      if (obs !== exp_b) begin
        errors++;
        $display("FAIL rmid_model c%0d got=%h want=%h", i, obs, exp_b);
      end
      if (i >= 3) begin
        checks++;
        if (obs !== '0) begin
          errors++;
          $display("FAIL rmid_quiet c%0d got=%h want=0", i, obs);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom);
      if ($urandom_range(0, 15) == 0) u_hang = ~u_hang;
      u_inj = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      checks++;
      if (obs !== exp_b) begin
        errors++;
        $display("FAIL rand_model c%0d got=%h want=%h", i, obs, exp_b);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; u_inj = 1'b0; u_hang = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unit_sched.md
UNIT_SCHED -- requirements
Module: unit_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the unit (2..8).
REQ-002 Parameter TIMEOUT, default 16, max cycles in WAIT before abort.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  requester i has a job pending.
REQ-006 req_ready  output  NUM_REQ  one-hot; job of requester i accepted this cycle.
REQ-007 done  output  NUM_REQ  one-hot pulse; job of requester i completed.
REQ-008 unit_ready  input  1  shared unit idle, can accept a job.
REQ-009 unit_valid  output  1  launch job on shared unit.
REQ-010 unit_done  input  1  shared unit completion pulse.
REQ-011 owner  output  clog2(NUM_REQ)  index of current/last granted requester.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 timeout_err  output  1  sticky; set on WAIT timeout.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT; state register updates on clk only.
REQ-015 IDLE: if any req_valid bit high, SHALL register winner into owner and go to ISSUE; else stay IDLE.
REQ-016 Winner SHALL be the first set req_valid bit searching upward from rr_ptr with wrap-around (NUM_REQ-1 wraps to 0).
REQ-017 ISSUE: unit_valid SHALL equal req_valid[owner]; req_ready[owner] SHALL equal req_valid[owner] & unit_ready.
REQ-018 ISSUE: on req_valid[owner] & unit_ready, SHALL go to WAIT and clear the cycle counter.
REQ-019 ISSUE: if req_valid[owner] is low, SHALL return to IDLE without launching; rr_ptr unchanged.
REQ-020 ISSUE with unit_ready low and request held: SHALL stay in ISSUE, unit_valid held high.
REQ-021 WAIT: done[owner] SHALL equal unit_done (combinational, same cycle); on unit_done go to IDLE and set rr_ptr = owner+1 mod NUM_REQ.
REQ-022 WAIT: counter SHALL increment each cycle without unit_done; at count TIMEOUT-1 without unit_done, go to IDLE, set timeout_err, no done pulse, rr_ptr = owner+1.
REQ-023 unit_done outside WAIT SHALL be ignored.
REQ-024 At most one job outstanding; minimum request-to-done latency is 1 (IDLE) + 1 (ISSUE) + unit latency.
REQ-025 req_valid changes on non-owner bits SHALL not affect the current transaction.
REQ-026 req_ready, done, unit_valid SHALL be zero in every state not named above for them.

Reset
REQ-027 reset SHALL force state=IDLE, rr_ptr=0, owner=0, counter=0, timeout_err=0.
REQ-028 After reset, req_ready=0, done=0, unit_valid=0, busy=0 in the following cycle.
REQ-029 reset mid-transaction (ISSUE or WAIT) SHALL abandon the job with no done pulse; a later unit_done SHALL be ignored.
REQ-030 timeout_err SHALL clear only on reset.

Structure
REQ-031 Shared package SHALL hold the state enum (IDLE, ISSUE, WAIT) and the default NUM_REQ/TIMEOUT constants.
REQ-032 Round-robin winner search SHALL be a sub-module rr_pick (inputs req vector, ptr; outputs any, index).
REQ-033 Counter width SHALL be clog2(TIMEOUT); no other arithmetic beyond modulo-NUM_REQ increment.

Verification
Bench models the shared unit as a 3-state IDLE/WAIT/DONE FSM: ready in IDLE, done 2 cycles after accept.
REQ-034 Single request: req_valid=0001 from cycle 0 -> req_ready[0] cycle 1, unit_valid cycle 1, done[0] cycle 3, busy cycles 1-3.
REQ-035 Fairness: req_valid=1111 held -> grant order 0,1,2,3,0 with one done per 4 cycles.
REQ-036 Wrap: rr_ptr=3, req_valid=0011 -> owner=0, then owner=1.
REQ-037 Timeout: unit never asserts done -> after 16 WAIT cycles timeout_err=1, state IDLE, done never pulses, next grant goes to owner+1.
REQ-038 Withdraw/reset: req_valid[2] dropped in ISSUE -> return to IDLE, no unit_valid; reset asserted in WAIT -> outputs 0 next cycle, subsequent unit_done produces no done.
